// File: rtl/constants_pkg.sv
// Shared constants and helpers for the pipeline controller slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package constants_pkg;

  localparam int PIPE_STAGES_DEFAULT = 5;
  localparam int PIPE_DATA_W_DEFAULT = 32;
  localparam int PERF_STALL_CNT_W    = 16;
  localparam int PERF_RETIRE_CNT_W   = 32;

  // Saturating increment for the per-stage stall counters.
  function automatic logic [PERF_STALL_CNT_W-1:0] sat_inc(input logic [PERF_STALL_CNT_W-1:0] v);
    return (&v) ? v : v + PERF_STALL_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline slot: valid bit plus payload register with flush/hold/load control.
// Latency: 1 cycle from load inputs to valid_q/data_q.
// Backpressure: hold keeps contents; flush clears valid (wins over hold/load).
module pipe_stage_reg
  import constants_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic              load_vld,
  input  logic [DATA_W-1:0] load_dat,
  output logic              valid_q,
  output logic [DATA_W-1:0] data_q
);

  logic              valid_d;
  logic [DATA_W-1:0] data_d;

  // Next state: flush kills, hold freezes, otherwise take upstream; payload only moves with a valid entry.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!hold) begin
      valid_d = load_vld;
      if (load_vld) begin
        data_d = load_dat;
      end
    end
  end

  // Slot registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// In-order pipeline of NUM_STAGES slots with per-stage stall, range flush and optional perf counters (PIPE_PERF_CNT_EN).
// Latency: NUM_STAGES cycles from accept at stage 0 to out_valid; one entry per cycle when unstalled.
// Backpressure: stalls propagate backwards only through valid stages (bubbles absorb them); in_ready drops when stage 0 is blocked or any flush is requested.
module pipeline_controller
  import constants_pkg::*;
#(
  parameter int NUM_STAGES = PIPE_STAGES_DEFAULT,
  parameter int DATA_W     = PIPE_DATA_W_DEFAULT
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  input  logic [DATA_W-1:0]                      in_data,
  output logic                                   in_ready,
  input  logic [NUM_STAGES-1:0]                  stall_req,
  input  logic [NUM_STAGES-1:0]                  flush_req,
  output logic [NUM_STAGES-1:0]                  stage_valid,
  output logic [NUM_STAGES*DATA_W-1:0]           stage_data,
  output logic [NUM_STAGES-1:0]                  stall_out,
  output logic                                   out_valid,
  output logic [DATA_W-1:0]                      out_data,
  output logic [NUM_STAGES*PERF_STALL_CNT_W-1:0] perf_stall_cnt,
  output logic [PERF_RETIRE_CNT_W-1:0]           perf_retire_cnt
);

  logic [NUM_STAGES-1:0] stage_vld;
  logic [DATA_W-1:0]     stage_dat [NUM_STAGES];
  logic [DATA_W-1:0]     stage_in  [NUM_STAGES];
  logic [NUM_STAGES-1:0] blocked;
  logic [NUM_STAGES-1:0] kill;
  logic [NUM_STAGES-1:0] load_vld;

  // Backward scan from the oldest stage: blocked chain and flush kill range (highest flush bit governs).
  always_comb begin
    logic blk_carry;
    logic kill_carry;
    blk_carry  = 1'b0;
    kill_carry = 1'b0;
    blocked    = '0;
    kill       = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      blocked[i] = stage_vld[i] & (stall_req[i] | blk_carry);
      blk_carry  = blocked[i];
      kill_carry = kill_carry | flush_req[i];
      kill[i]    = kill_carry;
    end
  end

  assign in_ready  = ~blocked[0] & ~(|flush_req);
  assign stall_out = blocked;

  // Per-stage load: stage 0 takes the accepted input; a stage fed by a killed stage gets a bubble.
  always_comb begin
    load_vld    = '0;
    stage_in[0] = in_data;
    load_vld[0] = in_valid & in_ready;
    for (int i = 1; i < NUM_STAGES; i++) begin
      stage_in[i] = stage_dat[i-1];
      load_vld[i] = stage_vld[i-1] & ~blocked[i-1] & ~kill[i-1];
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    pipe_stage_reg #(
      .DATA_W (DATA_W)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (kill[g]),
      .hold     (blocked[g]),
      .load_vld (load_vld[g]),
      .load_dat (stage_in[g]),
      .valid_q  (stage_vld[g]),
      .data_q   (stage_dat[g])
    );
  end

  // Flatten per-stage payloads onto the wide output bus.
  always_comb begin
    stage_data = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      stage_data[i*DATA_W +: DATA_W] = stage_dat[i];
    end
  end

  assign stage_valid = stage_vld;
  assign out_valid   = stage_vld[NUM_STAGES-1] & ~stall_req[NUM_STAGES-1];
  assign out_data    = stage_dat[NUM_STAGES-1];

`ifdef PIPE_PERF_CNT_EN
  logic [PERF_STALL_CNT_W-1:0]  stall_cnt_q [NUM_STAGES];
  logic [PERF_STALL_CNT_W-1:0]  stall_cnt_d [NUM_STAGES];
  logic [PERF_RETIRE_CNT_W-1:0] retire_cnt_q;
  logic [PERF_RETIRE_CNT_W-1:0] retire_cnt_d;

  // Stall counters saturate; retire counter wraps naturally.
  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      stall_cnt_d[i] = blocked[i] ? sat_inc(stall_cnt_q[i]) : stall_cnt_q[i];
    end
    retire_cnt_d = retire_cnt_q + PERF_RETIRE_CNT_W'(out_valid);
  end

  // Counter registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        stall_cnt_q[i] <= '0;
      end
      retire_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        stall_cnt_q[i] <= stall_cnt_d[i];
      end
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Flatten stall counters onto the wide output bus.
  always_comb begin
    perf_stall_cnt = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      perf_stall_cnt[i*PERF_STALL_CNT_W +: PERF_STALL_CNT_W] = stall_cnt_q[i];
    end
  end

  assign perf_retire_cnt = retire_cnt_q;
`else
  assign perf_stall_cnt  = '0;
  assign perf_retire_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller (NUM_STAGES=5, DATA_W=32) against a slot-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipeline_controller;

  localparam int NS = 5;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [DW-1:0]     in_data = '0;
  logic              in_ready;
  logic [NS-1:0]     stall_req = '0;
  logic [NS-1:0]     flush_req = '0;
  logic [NS-1:0]     stage_valid;
  logic [NS*DW-1:0]  stage_data;
  logic [NS-1:0]     stall_out;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [NS*16-1:0]  perf_stall_cnt;
  logic [31:0]       perf_retire_cnt;

  pipeline_controller #(
    .NUM_STAGES (NS),
    .DATA_W     (DW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .stall_req       (stall_req),
    .flush_req       (flush_req),
    .stage_valid     (stage_valid),
    .stage_data      (stage_data),
    .stall_out       (stall_out),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_retire_cnt (perf_retire_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: contents of each slot plus the perf counters.
  logic          mv [NS];
  logic [DW-1:0] md [NS];
  logic [15:0]   mstall [NS];
  logic [31:0]   mret;
  logic [DW-1:0] rq [$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A stage is blocked when it and every stage up to some stalling stage are all occupied.
  function automatic logic [NS-1:0] model_blocked();
    logic [NS-1:0] b;
    for (int i = 0; i < NS; i++) begin
      b[i] = 1'b0;
      for (int j = i; j < NS; j++) begin
        if (!mv[j]) break;
        if (stall_req[j]) begin
          b[i] = 1'b1;
          break;
        end
      end
    end
    return b;
  endfunction

  function automatic int flush_top();
    int k = -1;
    for (int i = 0; i < NS; i++) if (flush_req[i]) k = i;
    return k;
  endfunction

  function automatic logic model_ready();
    logic [NS-1:0] b = model_blocked();
    return !b[0] && (flush_req == '0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
      mstall[i] = '0;
    end
    mret = '0;
  endtask

  task automatic check_outputs();
    logic [NS-1:0]    b;
    logic [NS-1:0]    exp_sv;
    logic [NS*DW-1:0] exp_sd;
    logic [NS*16-1:0] exp_ps;
    logic [31:0]      exp_pr;
    b = model_blocked();
    exp_ps = '0;
    exp_pr = '0;
    for (int i = 0; i < NS; i++) begin
      exp_sv[i] = mv[i];
      exp_sd[i*DW +: DW] = md[i];
`ifdef PIPE_PERF_CNT_EN
      exp_ps[i*16 +: 16] = mstall[i];
`endif
    end
`ifdef PIPE_PERF_CNT_EN
    exp_pr = mret;
`endif
    check("stage_valid", stage_valid, exp_sv);
    check("stage_data", stage_data, exp_sd);
    check("stall_out", stall_out, b);
    check("in_ready", in_ready, model_ready());
    check("out_valid", out_valid, mv[NS-1] && !stall_req[NS-1]);
    check("out_data", out_data, md[NS-1]);
    check("perf_stall_cnt", perf_stall_cnt, exp_ps);
    check("perf_retire_cnt", perf_retire_cnt, exp_pr);
    if (out_valid) rq.push_back(out_data);
  endtask

  task automatic model_advance();
    logic [NS-1:0] b;
    logic          rdy;
    int            k;
    logic          nv [NS];
    logic [DW-1:0] nd [NS];
    logic          src_v;
    logic [DW-1:0] src_d;
    b   = model_blocked();
    rdy = model_ready();
    k   = flush_top();
    for (int i = 0; i < NS; i++) begin
      if (i <= k) begin
        nv[i] = 1'b0;
        nd[i] = md[i];
      end else if (b[i]) begin
        nv[i] = mv[i];
        nd[i] = md[i];
      end else begin
        if (i == 0) begin
          src_v = in_valid && rdy;
          src_d = in_data;
        end else begin
          src_v = mv[i-1] && !b[i-1] && (i - 1 > k);
          src_d = md[i-1];
        end
        nv[i] = src_v;
        nd[i] = src_v ? src_d : md[i];
      end
      if (b[i] && mstall[i] != 16'hFFFF) mstall[i] = mstall[i] + 16'd1;
    end
    if (mv[NS-1] && !stall_req[NS-1]) mret = mret + 32'd1;
    for (int i = 0; i < NS; i++) begin
      mv[i] = nv[i];
      md[i] = nd[i];
    end
  endtask

  // Check at the falling edge, advance the model, return just after the rising edge.
  task automatic run_cycle();
    @(negedge clk);
    check_outputs();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [NS-1:0] s, input logic [NS-1:0] f);
    in_valid  = v;
    in_data   = d;
    stall_req = s;
    flush_req = f;
  endtask

  initial begin
    int first;
    int sent;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Stall-free stream: latency and ordering.
    rq.delete();
    first = -1;
    for (int c = 0; c < 12; c++) begin
      drive(c < 5, 32'h10 + 32'(c), '0, '0);
      #1;
      if (first < 0 && out_valid) first = c;
      run_cycle();
    end
    check("latency", 32'(first), 32'd5);
    check("stream_count", 32'(rq.size()), 32'd5);
    for (int i = 0; i < 5 && i < rq.size(); i++) check("stream_data", rq[i], 32'h10 + 32'(i));

    // Mid-pipe stall on a full pipe.
    rq.delete();
    sent = 0;
    for (int c = 0; c < 30; c++) begin
      drive(sent < 16, 32'h20 + 32'(sent), (c >= 6 && c < 9) ? 5'b00100 : 5'b00000, '0);
      #1;
      if (c == 6) begin
        check("stall2_stall_out", stall_out, 5'b00111);
        check("stall2_in_ready", in_ready, 1'b0);
      end
      if (in_valid && model_ready()) sent++;
      run_cycle();
    end
    check("stall2_count", 32'(rq.size()), 32'd16);
    for (int i = 0; i < 16 && i < rq.size(); i++) check("stall2_data", rq[i], 32'h20 + 32'(i));

    // Bubbles absorb a stall at the oldest stage.
    for (int c = 0; c < 16; c++) begin
      drive(c == 0 || c == 4, (c == 0) ? 32'hAA : 32'hBB, (c == 5 || c == 6) ? 5'b10000 : 5'b00000, '0);
      #1;
      if (c == 5) begin
        check("bubble_stall_out", stall_out, 5'b10000);
        check("bubble_in_ready", in_ready, 1'b1);
        check("bubble_valid0", stage_valid, 5'b10001);
      end
      if (c == 6) check("bubble_valid1", stage_valid, 5'b10010);
      run_cycle();
    end

    // Flush of stages 0..2 on a full pipe.
    rq.delete();
    for (int c = 0; c < 14; c++) begin
      drive(c <= 5, (c == 5) ? 32'h99 : 32'h30 + 32'(c), '0, (c == 5) ? 5'b00100 : 5'b00000);
      #1;
      if (c == 5) begin
        check("flush_in_ready", in_ready, 1'b0);
        check("flush_full", stage_valid, 5'b11111);
      end
      if (c == 6) begin
        check("flush_after", stage_valid, 5'b10000);
        check("flush_s4_data", stage_data[4*DW +: DW], 32'h31);
      end
      run_cycle();
    end
    check("flush_retired", 32'(rq.size()), 32'd2);
    if (rq.size() >= 2) check("flush_order", {rq[0], rq[1]}, {32'h30, 32'h31});

    // Asynchronous reset with four entries in flight.
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 32'h40 + 32'(c), '0, '0);
      run_cycle();
    end
    drive(1'b0, '0, '0, '0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", stage_valid, '0);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_stall_out", stall_out, '0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_perf", {perf_stall_cnt, perf_retire_cnt}, '0);
    model_reset();
    @(posedge clk);
    #1;
    check("arst_edge_valid", stage_valid, '0);
    check("arst_edge_out_valid", out_valid, 1'b0);
    rst = 1'b0;

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      logic [NS-1:0] s;
      logic [NS-1:0] f;
      for (int i = 0; i < NS; i++) s[i] = ($urandom_range(0, 7) == 0);
      f = ($urandom_range(0, 24) == 0) ? NS'($urandom_range(1, 31)) : '0;
      drive($urandom_range(0, 3) != 0, $urandom, s, f);
      run_cycle();
    end

`ifdef PIPE_PERF_CNT_EN
    // Stall counter saturation and retire count.
    drive(1'b0, '0, '0, '0);
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(c == 0, 32'h50, '0, '0);
      run_cycle();
    end
    for (int c = 0; c < 70000; c++) begin
      drive(c < 2, 32'h51 + 32'(c), 5'b10000, '0);
      run_cycle();
    end
    check("perf_stall_sat", perf_stall_cnt[4*16 +: 16], 16'hFFFF);
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, '0, '0, '0);
      run_cycle();
    end
    check("perf_retire3", perf_retire_cnt, 32'd3);
`endif

    drive(1'b0, '0, '0, '0);
    run_cycle();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
